// File: rtl/delay_ramp_ctrl_pkg.sv
// Shared definitions for the delay ramp controller and its delay-line users.
package delay_ramp_ctrl_pkg;

  localparam int DELAY_WIDTH_DEF = 12;

  // Largest delay the delay line can address.
  localparam logic [DELAY_WIDTH_DEF-1:0] DELAY_MAX = '1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP_UP   = 2'd1,
    RAMP_DOWN = 2'd2
  } ramp_state_t;

endpackage

// File: rtl/delay_ramp_ctrl_tri.sv
// Triangle LFO: produces a 0..lfo_depth modulation offset that moves one
// sample per LFO tick, and decays smoothly to zero when disabled.
module tri_lfo
  import delay_ramp_ctrl_pkg::*;
#(
  parameter int DELAY_WIDTH   = DELAY_WIDTH_DEF,
  parameter int LFO_DIV_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sample_en,
  input  logic                     lfo_en,
  input  logic [DELAY_WIDTH-1:0]   lfo_depth,
  input  logic [LFO_DIV_WIDTH-1:0] lfo_rate,
  output logic [DELAY_WIDTH-1:0]   offset
);

  logic [LFO_DIV_WIDTH-1:0] div_cnt;
  logic                     dir_down;
  logic                     move_up;
  logic                     move_dn;
  logic                     dir_down_nxt;

  // Decide the direction of the next tick; an offset above a reduced depth
  // always heads down, and the triangle turns at depth and at zero.
  always_comb begin
    move_up      = !dir_down && (offset < lfo_depth);
    move_dn      = !move_up && (offset != '0);
    dir_down_nxt = 1'b0;
    if (move_up)
      dir_down_nxt = ((offset + DELAY_WIDTH'(1)) == lfo_depth);
    else if (move_dn)
      dir_down_nxt = (offset > DELAY_WIDTH'(1));
  end

  // Divider, direction and offset advance only on sample strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt  <= '0;
      dir_down <= 1'b0;
      offset   <= '0;
    end else if (sample_en) begin
      if (!lfo_en) begin
        if (offset != '0)
          offset <= offset - DELAY_WIDTH'(1);
        if (offset <= DELAY_WIDTH'(1)) begin
          div_cnt  <= '0;
          dir_down <= 1'b0;
        end
      end else if (div_cnt >= lfo_rate) begin
        div_cnt  <= '0;
        dir_down <= dir_down_nxt;
        if (move_up)
          offset <= offset + DELAY_WIDTH'(1);
        else if (move_dn)
          offset <= offset - DELAY_WIDTH'(1);
      end else begin
        div_cnt <= div_cnt + LFO_DIV_WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/delay_ramp_ctrl.sv
// Delay ramp controller: accepts delay targets over valid/ready, slews the
// base delay toward each target by a bounded step per audio sample, and adds
// triangle LFO modulation before driving the delay line.
module delay_ramp_ctrl
  import delay_ramp_ctrl_pkg::*;
#(
  parameter int DELAY_WIDTH   = DELAY_WIDTH_DEF,
  parameter int STEP_WIDTH    = 4,
  parameter int LFO_DIV_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sample_en,
  input  logic [DELAY_WIDTH-1:0]   target_delay,
  input  logic                     target_valid,
  output logic                     target_ready,
  input  logic [STEP_WIDTH-1:0]    step,
  input  logic                     lfo_en,
  input  logic [DELAY_WIDTH-1:0]   lfo_depth,
  input  logic [LFO_DIV_WIDTH-1:0] lfo_rate,
  output logic [DELAY_WIDTH-1:0]   delay_out,
  output logic                     settled
);

  localparam int SUM_W = DELAY_WIDTH + 1;

  ramp_state_t            state;
  logic [DELAY_WIDTH-1:0] cur;
  logic [DELAY_WIDTH-1:0] tgt;
  logic [DELAY_WIDTH-1:0] offset;
  logic [SUM_W-1:0]       diff;
  logic [SUM_W-1:0]       move;
  logic                   accept;
  logic                   vld_p1;

  // Step limited to the remaining distance; a zero step still makes progress.
  function automatic logic [SUM_W-1:0] clip_step(input logic [STEP_WIDTH-1:0] s,
                                                 input logic [SUM_W-1:0]      d);
    logic [SUM_W-1:0] s_eff;
    s_eff = (s == '0) ? SUM_W'(1) : SUM_W'(s);
    return (s_eff < d) ? s_eff : d;
  endfunction

  // Clamp the widened base+offset sum to the largest addressable delay.
  function automatic logic [DELAY_WIDTH-1:0] sat_delay(input logic [SUM_W-1:0] x);
    return x[DELAY_WIDTH] ? {DELAY_WIDTH{1'b1}} : x[DELAY_WIDTH-1:0];
  endfunction

  tri_lfo #(
    .DELAY_WIDTH   (DELAY_WIDTH),
    .LFO_DIV_WIDTH (LFO_DIV_WIDTH)
  ) u_lfo (
    .clk       (clk),
    .rst       (rst),
    .sample_en (sample_en),
    .lfo_en    (lfo_en),
    .lfo_depth (lfo_depth),
    .lfo_rate  (lfo_rate),
    .offset    (offset)
  );

  assign accept = target_valid && target_ready;

  // Remaining distance, widened by one bit so neither direction can wrap.
  always_comb begin
    diff = '0;
    if (state == RAMP_UP)
      diff = {1'b0, tgt} - {1'b0, cur};
    else if (state == RAMP_DOWN)
      diff = {1'b0, cur} - {1'b0, tgt};
    move = clip_step(step, diff);
  end

  // Handshake FSM and base-delay ramp; ready/settled are registered with the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cur          <= '0;
      tgt          <= '0;
      target_ready <= 1'b1;
      settled      <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            tgt <= target_delay;
            if (target_delay > cur) begin
              state        <= RAMP_UP;
              target_ready <= 1'b0;
              settled      <= 1'b0;
            end else if (target_delay < cur) begin
              state        <= RAMP_DOWN;
              target_ready <= 1'b0;
              settled      <= 1'b0;
            end
          end
        end
        RAMP_UP: begin
          if (sample_en) begin
            cur <= cur + move[DELAY_WIDTH-1:0];
            if (move == diff) begin
              state        <= IDLE;
              target_ready <= 1'b1;
              settled      <= 1'b1;
            end
          end
        end
        RAMP_DOWN: begin
          if (sample_en) begin
            cur <= cur - move[DELAY_WIDTH-1:0];
            if (move == diff) begin
              state        <= IDLE;
              target_ready <= 1'b1;
              settled      <= 1'b1;
            end
          end
        end
        default: begin
          state        <= IDLE;
          target_ready <= 1'b1;
          settled      <= 1'b1;
        end
      endcase
    end
  end

  // Stage p1: one cycle after the strobe, register the saturated base+offset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1    <= 1'b0;
      delay_out <= '0;
    end else begin
      vld_p1 <= sample_en;
      if (vld_p1)
        delay_out <= sat_delay({1'b0, cur} + {1'b0, offset});
    end
  end

endmodule
